// File: rtl/yc_separator_cfg.sv
// Configurable Y/C separator: boxcar or 2-sample comb; outputs 2 cycles after an accepted sample.
// No backpressure: every accepted sample yields one out_valid cycle; config change flushes and refills.
module yc_separator_cfg #(
    parameter int DATA_WIDTH   = 12,
    parameter int MAX_WIN_LOG2 = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         cfg_mode,
    input  logic        [2:0]            cfg_win_log2,
    output logic signed [DATA_WIDTH-1:0] luma_out,
    output logic signed [DATA_WIDTH-1:0] chroma_out,
    output logic                         out_valid,
    output logic                         busy
);
    localparam int TAPS = 1 << MAX_WIN_LOG2;
    localparam int SW   = DATA_WIDTH + MAX_WIN_LOG2;
    localparam int DW1  = DATA_WIDTH + 1;
    localparam int CW   = $clog2(TAPS + 1);
    localparam logic [2:0] WIN_MAX = 3'(MAX_WIN_LOG2);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic signed [DATA_WIDTH-1:0] tap [TAPS];
    logic signed [SW-1:0]         sum;
    logic signed [SW-1:0]         sum_nxt;
    logic        [CW-1:0]         fill_cnt;
    logic        [CW-1:0]         fill_tgt;
    logic        [CW-1:0]         cnt_nxt;
    logic                         act_mode;
    logic        [2:0]            act_win;
    logic        [2:0]            win_c;
    logic                         cfg_change;
    logic                         accept;
    logic                         s1_vld;
    logic                         s1_ok;
    logic [MAX_WIN_LOG2-1:0]      last_idx;
    logic [MAX_WIN_LOG2-1:0]      ctr_idx;
    logic signed [DATA_WIDTH-1:0] tap_last;
    logic signed [DATA_WIDTH-1:0] tap_ctr;
    logic signed [DATA_WIDTH-1:0] box_luma;
    logic signed [DW1-1:0]        box_diff;
    logic signed [DW1-1:0]        comb_add;
    logic signed [DW1-1:0]        comb_sub;
    logic signed [DATA_WIDTH-1:0] comb_luma;
    logic signed [DATA_WIDTH-1:0] luma_sel;
    logic signed [DATA_WIDTH-1:0] chroma_sel;

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [DW1-1:0] v);
        logic signed [DATA_WIDTH-1:0] r;
        if (v[DW1-1] != v[DW1-2]) begin
            r = v[DW1-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            r = v[DATA_WIDTH-1:0];
        end
        return r;
    endfunction

    // Clamping happens before comparison so out-of-range writes alias onto the active window.
    always_comb begin
        win_c = cfg_win_log2;
        if (cfg_win_log2 == 3'd0) begin
            win_c = 3'd1;
        end else if (cfg_win_log2 > WIN_MAX) begin
            win_c = WIN_MAX;
        end
    end

    assign cfg_change = (cfg_mode != act_mode) || (win_c != act_win);
    assign accept     = in_valid && (state != FLUSH);
    assign busy       = (state != RUN);

    // last_idx = N-1 (win low ones), ctr_idx = N/2 (single bit at win-1).
    always_comb begin
        last_idx = '0;
        ctr_idx  = '0;
        for (int i = 0; i < MAX_WIN_LOG2; i++) begin
            last_idx[i] = (i < int'(act_win));
            ctr_idx[i]  = (i + 1 == int'(act_win));
        end
    end

    always_comb begin
        tap_last   = tap[last_idx];
        tap_ctr    = tap[ctr_idx];
        sum_nxt    = sum + SW'(data_in) - SW'(tap_last);
        box_luma   = DATA_WIDTH'(sum >>> act_win);
        box_diff   = DW1'(tap_ctr) - DW1'(box_luma);
        comb_add   = DW1'(tap[0]) + DW1'(tap[2]);
        comb_sub   = DW1'(tap[0]) - DW1'(tap[2]);
        comb_luma  = DATA_WIDTH'(comb_add >>> 1);
        luma_sel   = act_mode ? comb_luma : box_luma;
        chroma_sel = act_mode ? sat(comb_sub >>> 1) : sat(box_diff);
        fill_tgt   = act_mode ? CW'(3) : (CW'(1) << act_win);
        cnt_nxt    = (fill_cnt >= fill_tgt) ? fill_cnt : fill_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // FILL hands over to RUN on the edge that publishes the first settled output.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (s1_vld && s1_ok) state_nxt = RUN;
            FLUSH:   state_nxt = FILL;
            default: state_nxt = state;
        endcase
        if (cfg_change) begin
            state_nxt = FLUSH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cfg_change) begin
            for (int i = 0; i < TAPS; i++) begin
                tap[i] <= '0;
            end
            sum        <= '0;
            fill_cnt   <= '0;
            s1_vld     <= 1'b0;
            s1_ok      <= 1'b0;
            out_valid  <= 1'b0;
            luma_out   <= '0;
            chroma_out <= '0;
            act_mode   <= cfg_mode;
            act_win    <= win_c;
        end else begin
            if (accept) begin
                tap[0] <= data_in;
                for (int i = 1; i < TAPS; i++) begin
                    tap[i] <= tap[i-1];
                end
                sum      <= sum_nxt;
                fill_cnt <= cnt_nxt;
            end
            s1_vld    <= accept;
            s1_ok     <= (state == RUN) || (cnt_nxt >= fill_tgt);
            out_valid <= s1_vld && s1_ok;
            if (s1_vld && s1_ok) begin
                luma_out   <= luma_sel;
                chroma_out <= chroma_sel;
            end
        end
    end

endmodule

// File: tb/tb_yc_separator_cfg.sv
// Randomized and directed bench for yc_separator_cfg against a sample-history reference model.
module tb_yc_separator_cfg;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic signed [11:0] data_in;
    logic               cfg_mode;
    logic        [2:0]  cfg_win_log2;
    logic signed [11:0] luma_out;
    logic signed [11:0] chroma_out;
    logic               out_valid;
    logic               busy;

    always #5 clk = ~clk;

    yc_separator_cfg #(.DATA_WIDTH(12), .MAX_WIN_LOG2(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .data_in      (data_in),
        .cfg_mode     (cfg_mode),
        .cfg_win_log2 (cfg_win_log2),
        .luma_out     (luma_out),
        .chroma_out   (chroma_out),
        .out_valid    (out_valid),
        .busy         (busy)
    );

    localparam int M_FILL  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: newest-first sample history plus one pending result in flight.
    int hist[$];
    int m_st, m_cnt, m_win;
    bit m_mode;
    bit p_has, p_ok;
    int p_l, p_c;
    int m_ov, m_l, m_c;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int h(input int i);
        return (i < hist.size()) ? hist[i] : 0;
    endfunction

    function automatic int sat12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    task automatic model_step(input bit rst, input bit iv, input int d, input bit md, input int wl);
        int wc, old, n, s;
        wc = (wl < 1) ? 1 : ((wl > 5) ? 5 : wl);
        if (rst || md != m_mode || wc != m_win) begin
            hist.delete();
            m_cnt  = 0;
            p_has  = 0;
            p_ok   = 0;
            m_ov   = 0;
            m_l    = 0;
            m_c    = 0;
            m_mode = md;
            m_win  = wc;
            m_st   = rst ? M_FILL : M_FLUSH;
            return;
        end
        old  = m_st;
        m_ov = 0;
        if (p_has && p_ok) begin
            m_ov = 1;
            m_l  = p_l;
            m_c  = p_c;
            if (old == M_FILL) m_st = M_RUN;
        end
        p_has = 0;
        if (old == M_FLUSH) begin
            m_st = M_FILL;
        end else if (iv) begin
            hist.push_front(d);
            if (hist.size() > 32) void'(hist.pop_back());
            m_cnt++;
            p_has = 1;
            p_ok  = (old == M_RUN) || (m_cnt >= (m_mode ? 3 : (1 << m_win)));
            if (m_mode) begin
                p_l = (h(0) + h(2)) >>> 1;
                p_c = sat12((h(0) - h(2)) >>> 1);
            end else begin
                n = 1 << m_win;
                s = 0;
                for (int i = 0; i < n; i++) s += h(i);
                p_l = s >>> m_win;
                p_c = sat12(h(n / 2) - p_l);
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit iv, input int d, input bit md, input int wl);
        rst_n        = ~rst;
        in_valid     = iv;
        data_in      = 12'(d);
        cfg_mode     = md;
        cfg_win_log2 = 3'(wl);
        @(posedge clk);
        model_step(rst, iv, d, md, wl);
        #1;
        check("out_valid", int'(out_valid), m_ov);
        check("busy", int'(busy), (m_st == M_RUN) ? 0 : 1);
        check("luma", int'(luma_out), m_l);
        check("chroma", int'(chroma_out), m_c);
    endtask

    int comb_pat[4] = '{1000, 1100, 1000, 900};

    initial begin
        bit r_md;
        int r_wl;
        rst_n = 1'b0; in_valid = 1'b0; data_in = '0; cfg_mode = 1'b0; cfg_win_log2 = 3'd5;
        m_st = M_FILL; m_cnt = 0; m_win = 5; m_mode = 0;
        p_has = 0; p_ok = 0; p_l = 0; p_c = 0; m_ov = 0; m_l = 0; m_c = 0;

        for (int i = 0; i < 5; i++) cyc(1, 1, 500, 0, 5);
        check("reset_busy", int'(busy), 1);
        check("reset_luma", int'(luma_out), 0);

        for (int i = 0; i < 64; i++) cyc(0, 1, 2000, 0, 5);
        cyc(0, 0, 0, 0, 5);
        cyc(0, 0, 0, 0, 5);
        check("dc_luma", int'(luma_out), 2000);
        check("dc_chroma", int'(chroma_out), 0);

        for (int i = 0; i < 160; i++) cyc(0, (i % 2) == 0, ((i / 2) % 2) ? 1000 : 1100, 0, 5);
        for (int i = 0; i < 40; i++) cyc(0, 1, (i % 2) ? 1000 : 1100, 0, 3);
        for (int i = 0; i < 40; i++) cyc(0, 1, comb_pat[i % 4], 1, 3);
        for (int i = 0; i < 20; i++) cyc(0, 1, (i % 2) ? -2048 : 2047, 0, 1);

        for (int i = 0; i < 6; i++) cyc(0, 1, 300 + i, 0, 0);
        for (int i = 0; i < 40; i++) cyc(0, 1, 300 - 7 * i, 0, 5);
        for (int i = 0; i < 6; i++) cyc(0, 1, 100 + i, 0, 7);
        check("clamp_busy", int'(busy), 0);

        r_md = 0;
        r_wl = 4;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                r_md = 1'($urandom_range(0, 1));
                r_wl = int'($urandom_range(0, 7));
            end
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 4095)) - 2048, r_md, r_wl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/yc_separator_cfg.md
Name: yc_separator_cfg

Overview:
- Run-time configurable successor to the fixed-window Y/C separator. It splits composite samples into luma and chroma.
- Two modes:
  - boxcar: luma = moving average over 2^win_log2 samples; chroma = centre tap minus luma.
  - 2-sample comb: matches 4fsc sampling, where the carrier inverts every 2 samples.
- Adds valid qualification, flush on configuration change, fill tracking, and chroma saturation.
- Sits between the ADC sample front-end and the chroma demodulator, in the 74.25 MHz video clock domain.

Parameters:
- DATA_WIDTH, 12, signed sample width of input and both outputs.
- MAX_WIN_LOG2, 5, log2 of the deepest window; the shift register holds 2^MAX_WIN_LOG2 taps.

Ports:
- clk  in  1  video sample clock.
- rst_n  in  1  synchronous reset, active-low, sampled on rising clk.
- in_valid  in  1  data_in is a new sample this cycle.
- data_in  in  DATA_WIDTH  signed composite sample.
- cfg_mode  in  1  0 = boxcar, 1 = comb.
- cfg_win_log2  in  3  boxcar window log2; clamped to [1, MAX_WIN_LOG2].
- luma_out  out  DATA_WIDTH  signed luma.
- chroma_out  out  DATA_WIDTH  signed chroma, saturated.
- out_valid  out  1  luma_out/chroma_out are a settled result.
- busy  out  1  block is flushing or filling after reset or a config change.

Behaviour:
- Reset (rst_n low at posedge):
  - clears all taps, running sum, fill counter and outputs to 0.
  - out_valid=0, busy=1, state=FILL.
  - Active config is loaded from the clamped cfg_* inputs.
  - Reset overrides every other event.
- Taps:
  - tap[0] is the newest accepted sample.
  - The shift register advances only on cycles where in_valid=1 and state is not FLUSH.
- Boxcar, N = 2^win:
  - sum_next = sum + data_in − tap[N−1], with tap[N−1] taken before the shift.
  - sum width is DATA_WIDTH+MAX_WIN_LOG2; sum never overflows.
  - luma = sum >>> win (arithmetic shift, floor).
  - chroma = tap[N/2] − luma, computed at DATA_WIDTH+1 bits, then saturated to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
- Comb:
  - luma = (tap[0] + tap[2]) >>> 1.
  - chroma = (tap[0] − tap[2]) >>> 1, saturated as above.
- Latency:
  - A sample accepted in cycle t updates taps and sum at edge t+1.
  - Outputs register at edge t+2, so out_valid is high in cycle t+2.
  - No stall: every accepted sample yields exactly one output cycle, and out_valid is 0 on bubble cycles.
- Outputs hold their last value when out_valid=0. They are not zeroed, except on reset or FLUSH.
- State machine:
  - FILL: count accepted samples. When the count reaches the fill target (N for boxcar, 3 for comb), go to RUN.
  - Outputs for samples accepted during FILL have out_valid=0. The sample that reaches the target produces out_valid=1.
  - RUN: normal operation.
  - Config change: in any state, if the clamped cfg_* differs from the active config, the next state is FLUSH.
  - FLUSH (exactly 1 cycle): clears taps, sum and outputs, loads the new active config, resets the fill counter, then goes to FILL.
  - in_valid during FLUSH drops that sample.
  - A config change during FILL restarts the flush.
- busy = 1 in FLUSH and FILL, 0 in RUN. busy falls in the same cycle out_valid first rises after fill.
- Out-of-range cfg_win_log2 is clamped before comparison, so writing 0 or 7 when already clamped does not trigger a flush.

Test Plan:
- Reset: rst_n=0 for 5 cycles with in_valid=1, data_in=500 → luma_out=0, chroma_out=0, out_valid=0, busy=1 throughout.
- DC: win=5, boxcar, 64 continuous samples of 2000 → out_valid first high 2 cycles after the 32nd sample, busy drops with it; then luma=2000, chroma=0 on every valid cycle.
- Carrier with bubbles: win=5, alternating 1100/1000, in_valid high every other cycle → out_valid pulses 2 cycles after each accepted sample; settled luma=1050, chroma alternates +50/−50.
- Mid-stream reconfig: in RUN with win=5, set win=3 → one FLUSH cycle (outputs 0, that sample dropped); busy=1 and out_valid=0 for the next 8 accepted samples; then luma=1050 and chroma ±50 again.
- Comb: mode=1, repeating 1000, 1100, 1000, 900 → out_valid from the 3rd sample; luma=1000, chroma cycles 0, +100, 0, −100 in phase with the input.
- Saturation: win=1, boxcar, alternating 2047/−2048 → luma=−1; chroma saturates to 2047 when the centre tap is 2047, and −2047 when it is −2048.
